// File: rtl/mux_21.sv
// rtl/mux_21.sv - registered 2:1 selector on a valid/ready stream with a one-entry skid buffer
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in1, in2   data sources; in1 chosen when sel=0, in2 when sel=1
//   sel        source select, sampled with the data on an accepted transfer
//   in_valid   upstream offers a transfer
//   in_ready   block can take a transfer this cycle (registered)
//   out        selected data, registered
//   out_valid  out holds an undelivered result
//   out_ready  downstream consumes out this cycle
module mux_21 #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] result;

  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;
  assign result  = sel ? in2 : in1;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (skid_valid_q) begin
      // in_ready is low while the skid holds data, so nothing new arrives;
      // the only move is promoting the skid entry once out is taken.
      if (out_ready) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_d       = result;
        out_valid_d = 1'b1;
      end else begin
        // Output stalled: park the result so in_ready can stay registered.
        skid_d       = result;
        skid_valid_d = 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= RESET_VAL;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_mux_21.sv
// tb/tb_mux_21.sv - directed-vector bench for mux_21 at WIDTH=1 and WIDTH=8
module tb_mux_21;

  logic clk;
  logic rst_n;

  logic       a_in1, a_in2, a_sel, a_in_valid, a_in_ready, a_out, a_out_valid, a_out_ready;
  logic [7:0] b_in1, b_in2, b_out;
  logic       b_sel, b_in_valid, b_in_ready, b_out_valid, b_out_ready;

  int n_total;
  int n_bad;

  mux_21 #(.WIDTH(1), .RESET_VAL(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .in1(a_in1), .in2(a_in2), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out(a_out), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_21 #(.WIDTH(8), .RESET_VAL(8'hC3)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in1(b_in1), .in2(b_in2), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out(b_out), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic s, input logic i1, input logic i2);
    a_in_valid = v; a_sel = s; a_in1 = i1; a_in2 = i2;
  endtask

  task automatic drive_b(input logic v, input logic s, input logic [7:0] i1, input logic [7:0] i2);
    b_in_valid = v; b_sel = s; b_in1 = i1; b_in2 = i2;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;

    // Reset state
    tick();
    check_eq("w1_rst_out", a_out, 1'b1);
    check_eq("w1_rst_valid", a_out_valid, 1'b0);
    check_eq("w1_rst_ready", a_in_ready, 1'b0);
    check_eq("w8_rst_out", b_out, 8'hC3);
    check_eq("w8_rst_valid", b_out_valid, 1'b0);
    check_eq("w8_rst_ready", b_in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("w1_ready_after_rel", a_in_ready, 1'b1);
    check_eq("w8_ready_after_rel", b_in_ready, 1'b1);

    // WIDTH=1 stream, one result per cycle
    drive_a(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("w1_t0_out", a_out, 1'b0);
    check_eq("w1_t0_valid", a_out_valid, 1'b1);
    drive_a(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("w1_t1_out", a_out, 1'b1);
    drive_a(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("w1_t2_out", a_out, 1'b1);
    check_eq("w1_t2_ready", a_in_ready, 1'b1);
    drive_a(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check_eq("w1_t3_out", a_out, 1'b1);
    check_eq("w1_t3_valid", a_out_valid, 1'b1);
    drive_a(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("w1_t4_out", a_out, 1'b0);
    drive_a(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("w1_idle_valid", a_out_valid, 1'b0);
    check_eq("w1_idle_out", a_out, 1'b0);

    // WIDTH=8 back-to-back
    drive_b(1'b1, 1'b1, 8'h00, 8'h5A);
    tick();
    check_eq("w8_bb0_out", b_out, 8'h5A);
    check_eq("w8_bb0_valid", b_out_valid, 1'b1);
    drive_b(1'b1, 1'b0, 8'hA5, 8'hFF);
    tick();
    check_eq("w8_bb1_out", b_out, 8'hA5);
    check_eq("w8_bb1_valid", b_out_valid, 1'b1);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check_eq("w8_idle_valid", b_out_valid, 1'b0);
    check_eq("w8_idle_out", b_out, 8'hA5);

    // Backpressure: A to out, B to skid, C refused until room
    b_out_ready = 1'b0;
    drive_b(1'b1, 1'b0, 8'h11, 8'hEE);
    tick();
    check_eq("bp_a_out", b_out, 8'h11);
    check_eq("bp_a_ready", b_in_ready, 1'b1);
    drive_b(1'b1, 1'b1, 8'hDD, 8'h22);
    tick();
    check_eq("bp_b_hold_out", b_out, 8'h11);
    check_eq("bp_b_ready", b_in_ready, 1'b0);
    drive_b(1'b1, 1'b0, 8'h33, 8'hCC);
    tick();
    check_eq("bp_c_hold_out", b_out, 8'h11);
    check_eq("bp_c_hold_valid", b_out_valid, 1'b1);
    check_eq("bp_c_ready", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    tick();
    check_eq("bp_rel_out_b", b_out, 8'h22);
    check_eq("bp_rel_valid", b_out_valid, 1'b1);
    check_eq("bp_rel_ready", b_in_ready, 1'b1);
    tick();
    check_eq("bp_out_c", b_out, 8'h33);
    check_eq("bp_out_c_valid", b_out_valid, 1'b1);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check_eq("bp_drain_valid", b_out_valid, 1'b0);
    check_eq("bp_drain_out", b_out, 8'h33);

    // Asynchronous reset with out and skid both occupied
    b_out_ready = 1'b0;
    drive_b(1'b1, 1'b1, 8'h00, 8'h44);
    tick();
    drive_b(1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("ar_pre_out", b_out, 8'h44);
    check_eq("ar_pre_ready", b_in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_out", b_out, 8'hC3);
    check_eq("ar_valid", b_out_valid, 1'b0);
    check_eq("ar_ready", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    check_eq("ar_rel_ready_pre", b_in_ready, 1'b0);
    tick();
    check_eq("ar_rel_ready", b_in_ready, 1'b1);
    check_eq("ar_rel_valid", b_out_valid, 1'b0);
    check_eq("ar_rel_out", b_out, 8'hC3);
    tick();
    check_eq("ar_no_skid_valid", b_out_valid, 1'b0);
    check_eq("ar_no_skid_out", b_out, 8'hC3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
